// File: rtl/bmp_pkg.sv
// Shared constants, state encoding and small helpers for the BMP stream parser.
package bmp_pkg;

    localparam logic [7:0]  BMP_SIG0        = 8'h42;
    localparam logic [7:0]  BMP_SIG1        = 8'h4D;

    localparam int unsigned OFF_FILE_SIZE   = 32'd2;
    localparam int unsigned OFF_DATA_OFFSET = 32'd10;
    localparam int unsigned OFF_WIDTH       = 32'd18;
    localparam int unsigned OFF_HEIGHT      = 32'd22;
    localparam int unsigned OFF_BIT_COUNT   = 32'd28;

    localparam logic [31:0] BMP_MIN_OFFSET  = 32'd30;
    // First index at which data_offset and file_size are both fully captured.
    localparam logic [31:0] BMP_CHECK_INDEX = 32'd14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        PIXEL  = 2'd2,
        ERROR  = 2'd3
    } bmp_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/bmp_stream_parser_if.sv
// Byte-stream input and parsed-header/qualifier outputs of the BMP stream parser.
interface bmp_stream_parser_if;

    logic        sof;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic [7:0]  byte_out;
    logic        byte_out_valid;
    logic        pixel_valid;
    logic        image_process_start;
    logic        header_done;
    logic        frame_done;
    logic        hdr_error;
    logic [31:0] file_size;
    logic [31:0] data_offset;
    logic [31:0] img_width;
    logic [31:0] img_height;
    logic [15:0] bit_count;

    modport master (
        output sof, byte_valid, byte_in,
        input  byte_out, byte_out_valid, pixel_valid, image_process_start,
               header_done, frame_done, hdr_error,
               file_size, data_offset, img_width, img_height, bit_count
    );

    modport slave (
        input  sof, byte_valid, byte_in,
        output byte_out, byte_out_valid, pixel_valid, image_process_start,
               header_done, frame_done, hdr_error,
               file_size, data_offset, img_width, img_height, bit_count
    );

endinterface

// File: rtl/bmp_le_field.sv
// Little-endian header field assembler: stores byte_in into the lane selected
// by idx when idx falls inside [OFFSET, OFFSET+NBYTES).
module bmp_le_field #(
    parameter int unsigned OFFSET = 0,
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [31:0]           idx,
    input  logic [7:0]            byte_in,
    output logic [8*NBYTES-1:0]   value
);

    logic [8*NBYTES-1:0] value_r;
    logic [8*NBYTES-1:0] value_nxt_s;
    logic [31:0]         lane_s;
    logic                hit_s;

    // Select the lane addressed by idx and merge the incoming byte.
    always_comb begin
        lane_s      = idx - OFFSET;
        hit_s       = (idx >= OFFSET) && (lane_s < NBYTES);
        value_nxt_s = value_r;
        if (clear) begin
            value_nxt_s = '0;
        end else if (wr_en && hit_s) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (lane_s == 32'(i)) begin
                    value_nxt_s[8*i +: 8] = byte_in;
                end else begin
                    value_nxt_s[8*i +: 8] = value_r[8*i +: 8];
                end
            end
        end else begin
            value_nxt_s = value_r;
        end
    end

    // Field storage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= '0;
        end else begin
            value_r <= value_nxt_s;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/bmp_stream_parser.sv
// BMP byte-stream receiver: parses the file header in-stream, validates it and
// qualifies pixel bytes for downstream point-processing blocks.
module bmp_stream_parser
    import bmp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    bmp_stream_parser_if.slave   bus
);

    bmp_state_e  state_r, state_nxt_s;
    logic [31:0] idx_r, idx_nxt_s;

    logic [7:0]  byte_out_r;
    logic        out_valid_r, out_valid_s;
    logic        pixel_valid_r, pixel_valid_s;
    logic        ips_r, ips_s;
    logic        header_done_r, header_done_s;
    logic        frame_done_r, frame_done_s;
    logic        hdr_error_r, hdr_error_s;

    logic        restart_s;
    logic        clear_s;
    logic        wr_s;
    logic        hdr_bad_s;

    logic [31:0] file_size_s;
    logic [31:0] data_offset_s;
    logic [31:0] img_width_s;
    logic [31:0] img_height_s;
    logic [15:0] bit_count_s;

    bmp_le_field #(.OFFSET(OFF_FILE_SIZE),   .NBYTES(4)) u_file_size (
        .clk(clk), .rst(rst), .clear(clear_s), .wr_en(wr_s),
        .idx(idx_r), .byte_in(bus.byte_in), .value(file_size_s)
    );
    bmp_le_field #(.OFFSET(OFF_DATA_OFFSET), .NBYTES(4)) u_data_offset (
        .clk(clk), .rst(rst), .clear(clear_s), .wr_en(wr_s),
        .idx(idx_r), .byte_in(bus.byte_in), .value(data_offset_s)
    );
    bmp_le_field #(.OFFSET(OFF_WIDTH),       .NBYTES(4)) u_width (
        .clk(clk), .rst(rst), .clear(clear_s), .wr_en(wr_s),
        .idx(idx_r), .byte_in(bus.byte_in), .value(img_width_s)
    );
    bmp_le_field #(.OFFSET(OFF_HEIGHT),      .NBYTES(4)) u_height (
        .clk(clk), .rst(rst), .clear(clear_s), .wr_en(wr_s),
        .idx(idx_r), .byte_in(bus.byte_in), .value(img_height_s)
    );
    bmp_le_field #(.OFFSET(OFF_BIT_COUNT),   .NBYTES(2)) u_bit_count (
        .clk(clk), .rst(rst), .clear(clear_s), .wr_en(wr_s),
        .idx(idx_r), .byte_in(bus.byte_in), .value(bit_count_s)
    );

    // Next-state, index and per-byte qualifier decode.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        out_valid_s   = 1'b0;
        pixel_valid_s = 1'b0;
        ips_s         = 1'b0;
        header_done_s = 1'b0;
        frame_done_s  = 1'b0;
        hdr_error_s   = hdr_error_r;
        clear_s       = 1'b0;
        wr_s          = 1'b0;
        // Fields at idx 14 come from registers updated by byte 13.
        hdr_bad_s     = (data_offset_s < BMP_MIN_OFFSET) || (file_size_s <= data_offset_s);
        restart_s     = bus.byte_valid && (bus.sof || (state_r == IDLE));

        if (restart_s) begin
            clear_s   = 1'b1;
            idx_nxt_s = 32'd1;
            if (bus.byte_in == BMP_SIG0) begin
                state_nxt_s = HEADER;
                out_valid_s = 1'b1;
                hdr_error_s = 1'b0;
            end else begin
                state_nxt_s = ERROR;
                hdr_error_s = 1'b1;
            end
        end else begin
            case (state_r)
                HEADER: begin
                    if ((idx_r == BMP_CHECK_INDEX) && hdr_bad_s) begin
                        state_nxt_s = ERROR;
                        hdr_error_s = 1'b1;
                    end else if (bus.byte_valid) begin
                        wr_s      = 1'b1;
                        idx_nxt_s = sat_inc(idx_r);
                        if ((idx_r == 32'd1) && (bus.byte_in != BMP_SIG1)) begin
                            state_nxt_s = ERROR;
                            hdr_error_s = 1'b1;
                        end else begin
                            out_valid_s = 1'b1;
                            if ((idx_r > BMP_CHECK_INDEX) && (idx_r == data_offset_s - 32'd1)) begin
                                state_nxt_s   = PIXEL;
                                header_done_s = 1'b1;
                            end else begin
                                state_nxt_s   = HEADER;
                            end
                        end
                    end else begin
                        state_nxt_s = HEADER;
                    end
                end
                PIXEL: begin
                    if (bus.byte_valid) begin
                        idx_nxt_s     = sat_inc(idx_r);
                        out_valid_s   = 1'b1;
                        pixel_valid_s = 1'b1;
                        ips_s         = 1'b1;
                        if (idx_r == file_size_s - 32'd1) begin
                            state_nxt_s  = IDLE;
                            frame_done_s = 1'b1;
                        end else begin
                            state_nxt_s  = PIXEL;
                        end
                    end else begin
                        ips_s = ips_r;
                    end
                end
                ERROR: begin
                    state_nxt_s = ERROR;
                end
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State, index and registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            idx_r         <= 32'd0;
            byte_out_r    <= 8'd0;
            out_valid_r   <= 1'b0;
            pixel_valid_r <= 1'b0;
            ips_r         <= 1'b0;
            header_done_r <= 1'b0;
            frame_done_r  <= 1'b0;
            hdr_error_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            idx_r         <= idx_nxt_s;
            byte_out_r    <= bus.byte_in;
            out_valid_r   <= out_valid_s;
            pixel_valid_r <= pixel_valid_s;
            ips_r         <= ips_s;
            header_done_r <= header_done_s;
            frame_done_r  <= frame_done_s;
            hdr_error_r   <= hdr_error_s;
        end
    end

    assign bus.byte_out            = byte_out_r;
    assign bus.byte_out_valid      = out_valid_r;
    assign bus.pixel_valid         = pixel_valid_r;
    assign bus.image_process_start = ips_r;
    assign bus.header_done         = header_done_r;
    assign bus.frame_done          = frame_done_r;
    assign bus.hdr_error           = hdr_error_r;
    assign bus.file_size           = file_size_s;
    assign bus.data_offset         = data_offset_s;
    assign bus.img_width           = img_width_s;
    assign bus.img_height          = img_height_s;
    assign bus.bit_count           = bit_count_s;

endmodule

// File: tb/tb_bmp_stream_parser.sv
// Self-checking bench for bmp_stream_parser: table-driven frame plus
// directed error, abort, random-gap and reset sequences.
module tb_bmp_stream_parser;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bmp_stream_parser_if bus();
    bmp_stream_parser dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic       sof;
        logic       valid;
        logic [7:0] b;
        logic [7:0] e_byte;
        logic [5:0] e_flags;   // {obv, pix, ips, hdone, fdone, err}
    } vec_t;

    vec_t       vtab[$];
    logic [7:0] fbuf [0:127];
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] flags();
        return {bus.byte_out_valid, bus.pixel_valid, bus.image_process_start,
                bus.header_done, bus.frame_done, bus.hdr_error};
    endfunction

    task automatic build(input int size, input int off, input int w, input int h, input int bc);
        for (int i = 0; i < 128; i++) fbuf[i] = 8'((i * 7 + 3) & 255);
        for (int i = 2; i < off && i < 128; i++) fbuf[i] = 8'h00;
        fbuf[0] = 8'h42;
        fbuf[1] = 8'h4D;
        for (int k = 0; k < 4; k++) begin
            fbuf[2 + k]  = 8'((size >> (8 * k)) & 255);
            fbuf[10 + k] = 8'((off  >> (8 * k)) & 255);
            fbuf[18 + k] = 8'((w    >> (8 * k)) & 255);
            fbuf[22 + k] = 8'((h    >> (8 * k)) & 255);
        end
        fbuf[14] = 8'd40;
        fbuf[26] = 8'd1;
        fbuf[28] = 8'(bc & 255);
        fbuf[29] = 8'((bc >> 8) & 255);
    endtask

    task automatic send(input logic s, input logic v, input logic [7:0] b);
        bus.sof        = s;
        bus.byte_valid = v;
        bus.byte_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, 32'(flags()), 32'd0);
        chk({tag, "_byte"},  32'(bus.byte_out), 32'd0);
        chk({tag, "_size"},  bus.file_size, 32'd0);
        chk({tag, "_off"},   bus.data_offset, 32'd0);
        chk({tag, "_w"},     bus.img_width, 32'd0);
        chk({tag, "_h"},     bus.img_height, 32'd0);
        chk({tag, "_bc"},    32'(bus.bit_count), 32'd0);
    endtask

    // Header error case: bytes 0..13 pass, byte 14 triggers ERROR, no header_done.
    task automatic hdr_err_seq(input string tag);
        int hd = 0;
        for (int i = 0; i < 30; i++) begin
            send(i == 0, 1'b1, fbuf[i]);
            if (bus.header_done) hd++;
            if (i < 14) begin
                chk($sformatf("%s_ok_%0d", tag, i), {30'd0, bus.byte_out_valid, bus.hdr_error}, 32'd2);
            end else begin
                chk($sformatf("%s_err_%0d", tag, i), {30'd0, bus.byte_out_valid, bus.hdr_error}, 32'd1);
            end
        end
        chk({tag, "_no_hdone"}, hd, 0);
    endtask

    initial begin
        vec_t v;
        int   sent, got, pixc, hdc, fdc, ipsh;
        logic vv;

        rst = 1'b1;
        bus.sof = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Table: 3x2 24-bit file with valid gaps in header and pixel phases.
        build(78, 54, 3, 2, 24);
        for (int i = 0; i < 78; i++) begin
            v.sof = (i == 0); v.valid = 1'b1; v.b = fbuf[i]; v.e_byte = fbuf[i];
            v.e_flags = {1'b1, i >= 54, i >= 54, i == 53, i == 77, 1'b0};
            vtab.push_back(v);
            if (i == 20 || i == 60) begin
                v.sof = 1'b0; v.valid = 1'b0; v.b = 8'hEE; v.e_byte = 8'hEE;
                v.e_flags = {1'b0, 1'b0, i == 60, 1'b0, 1'b0, 1'b0};
                vtab.push_back(v);
            end
        end
        v.sof = 1'b0; v.valid = 1'b0; v.b = 8'h00; v.e_byte = 8'h00; v.e_flags = 6'd0;
        vtab.push_back(v);
        foreach (vtab[k]) begin
            send(vtab[k].sof, vtab[k].valid, vtab[k].b);
            chk($sformatf("tab_flags_%0d", k), 32'(flags()), 32'(vtab[k].e_flags));
            if (vtab[k].e_flags[5]) chk($sformatf("tab_byte_%0d", k), 32'(bus.byte_out), 32'(vtab[k].e_byte));
        end
        chk("tab_size", bus.file_size, 32'd78);
        chk("tab_off",  bus.data_offset, 32'd54);
        chk("tab_w",    bus.img_width, 32'd3);
        chk("tab_h",    bus.img_height, 32'd2);
        chk("tab_bc",   32'(bus.bit_count), 32'd24);

        // Bad signature: dropped and sticky error until the next sof.
        send(1'b1, 1'b1, 8'h41);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("badsig_%0d", i), {30'd0, bus.byte_out_valid, bus.hdr_error}, 32'd1);
            send(1'b0, 1'b1, fbuf[i + 1]);
        end

        build(78, 20, 3, 2, 24);
        hdr_err_seq("off20");
        build(54, 54, 3, 2, 24);
        hdr_err_seq("size54");

        // Random 50% valid gaps: identical byte_out sequence.
        build(78, 54, 3, 2, 24);
        sent = 0; got = 0; pixc = 0; hdc = 0; fdc = 0;
        for (int cyc = 0; cyc < 1000 && got < 78; cyc++) begin
            vv = (sent < 78) ? 1'($urandom_range(0, 1)) : 1'b0;
            send(vv && sent == 0, vv, vv ? fbuf[sent] : 8'h00);
            if (vv) sent++;
            if (bus.byte_out_valid) begin
                if (got < 78) chk($sformatf("rand_byte_%0d", got), 32'(bus.byte_out), 32'(fbuf[got]));
                got++;
            end
            if (bus.pixel_valid) pixc++;
            if (bus.header_done) hdc++;
            if (bus.frame_done) fdc++;
        end
        chk("rand_count", got, 78);
        chk("rand_pix", pixc, 24);
        chk("rand_hdone", hdc, 1);
        chk("rand_fdone", fdc, 1);

        // Abort at pixel byte 10, then a full 2x2 file.
        fdc = 0;
        for (int i = 0; i < 64; i++) begin
            send(i == 0, 1'b1, fbuf[i]);
            if (bus.frame_done) fdc++;
        end
        chk("abort_ips_before", 32'(bus.image_process_start), 32'd1);
        build(70, 54, 2, 2, 24);
        hdc = 0; ipsh = 0; pixc = 0;
        for (int i = 0; i < 70; i++) begin
            send(i == 0, 1'b1, fbuf[i]);
            if (bus.frame_done && i != 69) fdc++;
            if (i < 54 && bus.image_process_start) ipsh++;
            if (bus.header_done) hdc++;
            if (bus.pixel_valid) pixc++;
            if (i == 69) chk("abort_fdone_last", 32'(bus.frame_done), 32'd1);
        end
        chk("abort_no_fdone", fdc, 0);
        chk("abort_ips_hdr", ipsh, 0);
        chk("abort_hdone", hdc, 1);
        chk("abort_pix", pixc, 16);
        chk("abort_w", bus.img_width, 32'd2);
        chk("abort_h", bus.img_height, 32'd2);
        chk("abort_size", bus.file_size, 32'd70);

        // Asynchronous reset mid-pixel, then parse from byte 0 without sof.
        build(78, 54, 3, 2, 24);
        for (int i = 0; i < 60; i++) send(i == 0, 1'b1, fbuf[i]);
        chk("prerst_ips", 32'(bus.image_process_start), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_zero("async_rst");
        bus.byte_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        fdc = 0;
        for (int i = 0; i < 78; i++) begin
            send(1'b0, 1'b1, fbuf[i]);
            if (i == 0) chk("postrst_b0", {30'd0, bus.byte_out_valid, bus.hdr_error}, 32'd2);
            if (bus.frame_done) fdc++;
        end
        chk("postrst_fdone", fdc, 1);
        chk("postrst_off", bus.data_offset, 32'd54);
        chk("postrst_bc", 32'(bus.bit_count), 32'd24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bmp_stream_parser.md
# bmp_stream_parser

Hardware receiver for the BMP byte stream that the image-process benches drive into point-processing blocks such as contrast_adjust. It parses the BMP file header in-stream (signature, file size, pixel-data offset, width, height, bit depth) and splits the stream into header bytes and pixel bytes. It also generates the image_process_start qualifier in hardware, so downstream point blocks process only pixel bytes. It sits between the byte source (file reader, DMA, or UART) and the point-processing chain.

## Interface
- No parameters; all field offsets and limits are package constants.
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-high
- sof  in  1  start of file; qualified by byte_valid, marks byte 0
- byte_valid  in  1  byte_in valid this cycle
- byte_in  in  8  stream byte
- byte_out  out  8  byte_in delayed one cycle
- byte_out_valid  out  1  byte_valid delayed one cycle; low while in ERROR
- pixel_valid  out  1  byte_out is a pixel byte (index ≥ data_offset)
- image_process_start  out  1  level; high from first pixel byte until frame end
- header_done  out  1  one-cycle pulse with the last header byte on byte_out
- frame_done  out  1  one-cycle pulse with the last file byte on byte_out
- hdr_error  out  1  sticky error flag
- file_size  out  32  bytes 2..5, little-endian
- data_offset  out  32  bytes 10..13
- img_width  out  32  bytes 18..21
- img_height  out  32  bytes 22..25
- bit_count  out  16  bytes 28..29

## Operation
- Reset value of every output is 0; the state is IDLE and the byte index is 0.
- States:
  - IDLE: the next valid byte is byte 0, with or without sof. Go to HEADER with index = 1.
  - HEADER: capture the fields at their offsets, little-endian; the first byte received is the LSB.
  - PIXEL: pass pixel bytes through.
  - ERROR: drop bytes.
- Index counter: 32 bits. It increments on each valid byte and does not wrap.
- Signature check:
  - byte 0 must be 0x42 and byte 1 must be 0x4D.
  - On mismatch, go to ERROR and set hdr_error.
- Offset and size check, at index 14 (data_offset complete):
  - data_offset must be ≥ 30, else ERROR.
  - At index 14, file_size must be > data_offset, else ERROR.
- HEADER → PIXEL when the byte with index data_offset−1 is accepted. header_done pulses with that byte on byte_out.
- PIXEL: pixel_valid and image_process_start assert with the byte at index data_offset on byte_out.
- PIXEL → IDLE when the byte with index file_size−1 is accepted:
  - frame_done pulses with that byte on byte_out.
  - image_process_start drops the cycle after.
  - The captured fields hold until the next sof or byte 0.
- sof with byte_valid in any state, including ERROR and mid-frame:
  - Restart: the byte is treated as byte 0.
  - Fields clear to 0 and hdr_error clears.
  - image_process_start drops.
  - No frame_done is issued for the aborted frame.
- ERROR exits only on sof or rst.
- byte_valid low: the index and state hold; pixel_valid and byte_out_valid are low that cycle; image_process_start holds.
- rst mid-frame: all outputs return to 0 immediately (asynchronous).

## Timing
- Latency: fixed 1 cycle from byte_in/byte_valid to byte_out and all qualifiers. No backpressure; one byte per cycle max.
- A field output updates the cycle after its final byte is accepted. Partial fields are visible during capture.
- header_done and frame_done never coincide with each other, because file_size > data_offset.
- Minimum file (size = offset+1): header_done, then frame_done on the next valid byte.

## Structure
- Package bmp_pkg holds:
  - constants BMP_SIG0 = 8'h42 and BMP_SIG1 = 8'h4D;
  - field offsets 2, 10, 18, 22, 28;
  - BMP_MIN_OFFSET = 30;
  - the state enum IDLE/HEADER/PIXEL/ERROR.
- Sub-module bmp_le_field: a little-endian byte assembler with index compare, instantiated once per captured field.

## Test plan
- 3×2 24-bit BMP: offset 54, size 78 (rows padded to 12 bytes). Expect 54 bytes with pixel_valid=0, header_done at byte 53, then 24 pixel bytes. Expect frame_done at byte 77, img_width=3, img_height=2, bit_count=24.
- First byte 0x41: ERROR the cycle after; byte_out_valid=0 for the rest of the stream; hdr_error=1 until the next sof.
- Header with data_offset=20: ERROR at index 14 and no header_done.
- Header with file_size=54 and offset=54: ERROR at index 14.
- byte_valid toggled 50% randomly on the 78-byte file: identical byte_out sequence, with pixel_valid count 24.
- sof at pixel byte 10, then a full second file: no frame_done for the first; fields re-captured; image_process_start low for the second file's 54 header cycles.
- rst asserted mid-pixel: all outputs 0 asynchronously; after release, the next byte parses as byte 0.
